// File: rtl/apb_drp_pkg.sv
// apb_drp_pkg: shared state type and DRP data width for the APB-to-DRP bridge.
package apb_drp_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} drp_bridge_state_t;
  localparam int DRP_DATA_WIDTH = 16;
endpackage

// File: rtl/apb_drp_bridge.sv
// apb_drp_bridge: APB completer turning 32-bit register accesses into single 16-bit DRP
// transactions, with a timeout so a dead transceiver answers PSLVERR instead of hanging.
module apb_drp_bridge
  import apb_drp_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 10,
  parameter int DRP_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]               pwdata,
  input  logic [3:0]                pstrb,
  output logic                      pready,
  output logic [31:0]               prdata,
  output logic                      pslverr,
  output logic                      drp_en,
  output logic                      drp_we,
  output logic [DRP_ADDR_WIDTH-1:0] drp_addr,
  output logic [DRP_DATA_WIDTH-1:0] drp_di,
  input  logic [DRP_DATA_WIDTH-1:0] drp_do,
  input  logic                      drp_rdy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  drp_bridge_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pready_q, pready_d, pslverr_q, pslverr_d, drp_en_q, drp_en_d, drp_we_q, drp_we_d, wr_q, wr_d;
  logic [31:0] prdata_q, prdata_d;
  logic [DRP_ADDR_WIDTH-1:0] drp_addr_q, drp_addr_d;
  logic [DRP_DATA_WIDTH-1:0] drp_di_q, drp_di_d;
  logic bad;
  logic unused_bits;
  assign unused_bits = ^{pwdata[31:16], pstrb[3:2]};
  assign bad = (|paddr[1:0]) || ((paddr >> (DRP_ADDR_WIDTH + 2)) != '0) || (pwrite && pstrb[1:0] != 2'b11);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    drp_en_d   = 1'b0;
    drp_we_d   = 1'b0;
    wr_d       = wr_q;
    drp_addr_d = drp_addr_q;
    drp_di_d   = drp_di_q;
    case (state_q)
      IDLE: if (psel && penable) begin
        if (bad) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = DONE;
        end else begin
          drp_en_d   = 1'b1;
          drp_we_d   = pwrite;
          wr_d       = pwrite;
          drp_addr_d = paddr[DRP_ADDR_WIDTH+1:2];
          drp_di_d   = pwrite ? pwdata[DRP_DATA_WIDTH-1:0] : '0;
          cnt_d      = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // a response landing on the timeout cycle still counts as success
        if (drp_rdy) begin
          pready_d = 1'b1;
          prdata_d = wr_q ? '0 : {{(32-DRP_DATA_WIDTH){1'b0}}, drp_do};
          state_d  = DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      drp_en_q   <= 1'b0;
      drp_we_q   <= 1'b0;
      wr_q       <= 1'b0;
      drp_addr_q <= '0;
      drp_di_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      drp_en_q   <= drp_en_d;
      drp_we_q   <= drp_we_d;
      wr_q       <= wr_d;
      drp_addr_q <= drp_addr_d;
      drp_di_q   <= drp_di_d;
    end
  end
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign prdata   = prdata_q;
  assign drp_en   = drp_en_q;
  assign drp_we   = drp_we_q;
  assign drp_addr = drp_addr_q;
  assign drp_di   = drp_di_q;
endmodule

// File: tb/tb_apb_drp_bridge.sv
// tb_apb_drp_bridge: directed APB transfers against a delay-programmable DRP responder;
// expected responses are queued per transfer and checked by a monitor on pready.
module tb_apb_drp_bridge;
  import apb_drp_pkg::*;
  localparam int T = 255;
  logic pclk = 0, presetn = 0, psel = 0, penable = 0, pwrite = 0;
  logic [9:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0] pstrb = '0;
  logic pready, pslverr, drp_en, drp_we;
  logic [31:0] prdata;
  logic [7:0] drp_addr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic drp_rdy = 0;

  apb_drp_bridge #(.APB_ADDR_WIDTH(10), .DRP_ADDR_WIDTH(8), .TIMEOUT_CYCLES(T)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr),
    .drp_di(drp_di), .drp_do(drp_do), .drp_rdy(drp_rdy)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {logic [31:0] data; logic err;} exp_t;
  exp_t sb_q[$];
  int tests = 0, fails = 0;
  int en_cnt = 0;
  logic last_we = 0;
  logic [7:0] last_addr = '0;
  logic [15:0] last_di = '0;
  int rsp_delay = 0, cd = -1, stray_req = 0, stray_done = 0;
  bit rsp_on = 1;
  logic [15:0] rsp_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops one expected response per pready and watches the DRP side
  always @(negedge pclk) begin
    if (pready) begin
      check("pready_in_access", {31'b0, psel && penable}, 32'd1);
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pready: got pready=1 expected no transfer pending (prdata %h)", prdata);
      end else begin : pop
        exp_t e;
        e = sb_q.pop_front();
        check("prdata", prdata, e.data);
        check("pslverr", {31'b0, pslverr}, {31'b0, e.err});
      end
    end
    if (drp_we) check("we_only_with_en", {31'b0, drp_en}, 32'd1);
    if (drp_en) begin
      en_cnt++;
      last_we = drp_we;
      last_addr = drp_addr;
      last_di = drp_di;
    end
  end

  // DRP responder: drp_rdy pulses rsp_delay cycles after the drp_en cycle (0 = same cycle)
  always @(negedge pclk) begin
    drp_rdy = 0;
    if (drp_en && rsp_on) cd = rsp_delay;
    if (cd == 0) begin
      drp_rdy = 1;
      drp_do = rsp_data;
    end
    if (cd >= 0) cd--;
    if (stray_req != stray_done) begin
      drp_rdy = 1;
      drp_do = 16'hBAD0;
      stray_done = stray_req;
    end
  end

  task automatic apb(input logic wr, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp_data, input logic exp_err, input int exp_cyc, input string name);
    int cyc;
    sb_q.push_back('{data: exp_data, err: exp_err});
    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1;
    cyc = 1;
    while (1) begin
      @(negedge pclk);
      if (pready || cyc >= 400) break;
      @(posedge pclk); #1;
      cyc++;
    end
    check({name, "_cycles"}, cyc, exp_cyc);
    @(posedge pclk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {4'b0, pready, pslverr, drp_en, drp_we, drp_addr, drp_di}, 32'd0);
    check({name, "_prdata"}, prdata, 32'd0);
  endtask

  initial begin
    int e0;
    repeat (3) @(posedge pclk);
    #1 check_all_zero("reset");
    @(negedge pclk) presetn = 1;

    e0 = en_cnt; rsp_on = 1; rsp_delay = 3; rsp_data = 16'h5555;
    apb(1, 10'h010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 6, "wr_basic");
    check("wr_en_pulses", en_cnt - e0, 1);
    check("wr_we", {31'b0, last_we}, 1);
    check("wr_addr", {24'b0, last_addr}, 32'h04);
    check("wr_di", {16'b0, last_di}, 32'hBEEF);
    check("wr_addr_hold", {24'b0, drp_addr}, 32'h04);

    e0 = en_cnt; rsp_delay = 0; rsp_data = 16'h1234;
    apb(0, 10'h3FC, 32'h0, 4'h0, 32'h0000_1234, 0, 3, "rd_zero_wait");
    check("rd_en_pulses", en_cnt - e0, 1);
    check("rd_we", {31'b0, last_we}, 0);
    check("rd_addr", {24'b0, last_addr}, 32'hFF);
    check("rd_di", {16'b0, last_di}, 32'h0);

    // no response: pready in access cycle T+2, i.e. drp_en cycle through pready cycle spans T+1 cycles
    e0 = en_cnt; rsp_on = 0;
    apb(0, 10'h020, 32'h0, 4'h0, 32'h0, 1, T + 2, "rd_timeout");
    check("to_en_pulses", en_cnt - e0, 1);
    repeat (10) @(posedge pclk);
    #1 stray_req++;
    repeat (4) @(posedge pclk);
    #1 check("stray_no_en", en_cnt - e0, 1);
    rsp_on = 1; rsp_delay = 1; rsp_data = 16'hA5A5;
    apb(0, 10'h024, 32'h0, 4'h0, 32'h0000_A5A5, 0, 4, "rd_after_stray");

    e0 = en_cnt;
    apb(1, 10'h030, 32'h1111, 4'b0001, 32'h0, 1, 2, "wr_bad_strb");
    apb(0, 10'h002, 32'h0, 4'h0, 32'h0, 1, 2, "rd_misaligned");
    check("bad_no_en", en_cnt - e0, 0);

    rsp_delay = 0; rsp_data = 16'h7777;
    apb(1, 10'h040, 32'hFFFF_0042, 4'b0011, 32'h0, 0, 3, "wr_low_strb");
    check("wr_low_di", {16'b0, last_di}, 32'h0042);
    check("wr_low_addr", {24'b0, last_addr}, 32'h10);

    // reset two cycles after drp_en, with drp_rdy arriving while reset is held
    rsp_delay = 3; rsp_data = 16'hEEEE;
    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = 10'h050;
    @(posedge pclk); #1 penable = 1;
    @(posedge pclk); #1 check("rst_drp_en_seen", {31'b0, drp_en}, 1);
    @(posedge pclk);
    @(posedge pclk); #1 presetn = 0;
    #1 check_all_zero("rst_mid");
    repeat (3) @(posedge pclk);
    #1 check_all_zero("rst_held");
    check("rst_state", {30'b0, dut.state_q}, {30'b0, IDLE});
    psel = 0; penable = 0;
    @(negedge pclk) presetn = 1;
    rsp_delay = 0; rsp_data = 16'hCAFE;
    apb(0, 10'h054, 32'h0, 4'h0, 32'h0000_CAFE, 0, 3, "rd_after_reset");

    rsp_delay = T - 1; rsp_data = 16'h0F0F;
    apb(0, 10'h060, 32'h0, 4'h0, 32'h0000_0F0F, 0, T + 2, "rd_rdy_at_timeout");

    repeat (3) @(posedge pclk);
    #1 check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
